// File: rtl/dmem_arbiter.sv
// Two-master data-memory arbiter: CPU and an external master share one port.
// Round-robin on contention, with a bounded EXT burst lock.
module dmem_arbiter #(
    parameter int LOCK_MAX = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [2:0]  cpu_store_type,
    input  logic [2:0]  cpu_load_type,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_rdata,
    input  logic        ext_req,
    input  logic        ext_we,
    input  logic        ext_lock,
    input  logic [31:0] ext_addr,
    input  logic [31:0] ext_wdata,
    input  logic [2:0]  ext_store_type,
    input  logic [2:0]  ext_load_type,
    output logic        ext_gnt,
    output logic        ext_rvalid,
    output logic [31:0] ext_rdata,
    output logic        d_wr_en,
    output logic [31:0] dAddr,
    output logic [31:0] dWdata,
    output logic [2:0]  store_type,
    output logic [2:0]  load_type,
    input  logic [31:0] dRdata
);
    localparam int CW = $clog2(LOCK_MAX + 1);
    localparam logic [CW-1:0] LMAX = CW'(LOCK_MAX);

    typedef enum logic [1:0] {IDLE, OWN_CPU, OWN_EXT} state_e;

    state_e        state_q, state_d;
    logic          last_ext_q, last_ext_d;
    logic [CW-1:0] lock_cnt_q, lock_cnt_d;
    logic          ld_q, ld_d;
    logic [31:0]   cpu_rdata_q, cpu_rdata_d;
    logic [31:0]   ext_rdata_q, ext_rdata_d;
    logic          owner_we;
    logic          lock_win;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            last_ext_q  <= 1'b1;
            lock_cnt_q  <= '0;
            ld_q        <= 1'b0;
            cpu_rdata_q <= '0;
            ext_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_ext_q  <= last_ext_d;
            lock_cnt_q  <= lock_cnt_d;
            ld_q        <= ld_d;
            cpu_rdata_q <= cpu_rdata_d;
            ext_rdata_q <= ext_rdata_d;
        end
    end

    // state_d is the owner of the current cycle; reset low forces IDLE.
    assign lock_win = last_ext_q & ext_lock & ext_req & (lock_cnt_q < LMAX);

    always_comb begin
        state_d = IDLE;
        if (!reset)
            state_d = IDLE;
        else if (lock_win)
            state_d = OWN_EXT;
        else if (cpu_req && ext_req)
            state_d = last_ext_q ? OWN_CPU : OWN_EXT;
        else if (cpu_req)
            state_d = OWN_CPU;
        else if (ext_req)
            state_d = OWN_EXT;
    end

    always_comb begin
        cpu_gnt    = 1'b0;
        ext_gnt    = 1'b0;
        owner_we   = 1'b0;
        dAddr      = '0;
        dWdata     = '0;
        store_type = '0;
        load_type  = '0;
        case (state_d)
            OWN_CPU: begin
                cpu_gnt    = 1'b1;
                owner_we   = cpu_we;
                dAddr      = cpu_addr;
                dWdata     = cpu_wdata;
                store_type = cpu_store_type;
                load_type  = cpu_load_type;
            end
            OWN_EXT: begin
                ext_gnt    = 1'b1;
                owner_we   = ext_we;
                dAddr      = ext_addr;
                dWdata     = ext_wdata;
                store_type = ext_store_type;
                load_type  = ext_load_type;
            end
            default: ;
        endcase
        d_wr_en = owner_we & (cpu_gnt | ext_gnt);

        last_ext_d = last_ext_q;
        if (state_d != IDLE)
            last_ext_d = (state_d == OWN_EXT);

        lock_cnt_d = '0;
        if (state_d == OWN_EXT && ext_lock)
            lock_cnt_d = (lock_cnt_q == LMAX) ? LMAX : lock_cnt_q + CW'(1);

        ld_d        = (state_d != IDLE) & ~owner_we;
        cpu_rdata_d = (cpu_gnt & ~cpu_we) ? dRdata : cpu_rdata_q;
        ext_rdata_d = (ext_gnt & ~ext_we) ? dRdata : ext_rdata_q;
    end

    assign cpu_rvalid = (state_q == OWN_CPU) & ld_q;
    assign ext_rvalid = (state_q == OWN_EXT) & ld_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign ext_rdata  = ext_rdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small word-addressed memory model.
module tb_dmem_arbiter;
    logic        clk;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [2:0]  cpu_store_type, cpu_load_type;
    logic        cpu_gnt, cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        ext_req, ext_we, ext_lock;
    logic [31:0] ext_addr, ext_wdata;
    logic [2:0]  ext_store_type, ext_load_type;
    logic        ext_gnt, ext_rvalid;
    logic [31:0] ext_rdata;
    logic        d_wr_en;
    logic [31:0] dAddr, dWdata, dRdata;
    logic [2:0]  store_type, load_type;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem [0:15] = '{4: 32'hDEADBEEF, default: 32'h0};

    assign dRdata = mem[dAddr[5:2]];

    always @(posedge clk)
        if (d_wr_en) mem[dAddr[5:2]] <= dWdata;

    dmem_arbiter #(.LOCK_MAX(8)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_store_type(cpu_store_type), .cpu_load_type(cpu_load_type),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .ext_req(ext_req), .ext_we(ext_we), .ext_lock(ext_lock),
        .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_store_type(ext_store_type), .ext_load_type(ext_load_type),
        .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
        .d_wr_en(d_wr_en), .dAddr(dAddr), .dWdata(dWdata),
        .store_type(store_type), .load_type(load_type), .dRdata(dRdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_cpu(input logic req, input logic we,
                           input logic [31:0] a, input logic [31:0] d);
        cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic drv_ext(input logic req, input logic we, input logic lk,
                           input logic [31:0] a, input logic [31:0] d);
        ext_req = req; ext_we = we; ext_lock = lk; ext_addr = a; ext_wdata = d;
    endtask

    initial begin
        reset = 1'b0;
        drv_cpu(1'b1, 1'b1, 32'h30, 32'h55);
        drv_ext(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        cpu_store_type = 3'b0; cpu_load_type = 3'b0;
        ext_store_type = 3'b0; ext_load_type = 3'b0;
        #3;
        chk("rst_cpu_gnt", cpu_gnt, 0);
        chk("rst_ext_gnt", ext_gnt, 0);
        chk("rst_wr_en", d_wr_en, 0);
        chk("rst_daddr", dAddr, 0);
        chk("rst_cpu_rvalid", cpu_rvalid, 0);
        chk("rst_ext_rvalid", ext_rvalid, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_ext_rdata", ext_rdata, 0);
        drv_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        reset = 1'b1;

        // CPU-only load
        drv_cpu(1'b1, 1'b0, 32'h10, 32'h0);
        #1;
        chk("s1_cpu_gnt", cpu_gnt, 1);
        chk("s1_ext_gnt", ext_gnt, 0);
        chk("s1_daddr", dAddr, 32'h10);
        chk("s1_wr_en", d_wr_en, 0);
        tick();
        drv_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("s1_rvalid", cpu_rvalid, 1);
        chk("s1_rdata", cpu_rdata, 32'hDEADBEEF);
        chk("s1_ext_rvalid", ext_rvalid, 0);
        chk("s1_idle_daddr", dAddr, 0);
        tick();
        chk("s1_rvalid_drop", cpu_rvalid, 0);
        chk("s1_rdata_hold", cpu_rdata, 32'hDEADBEEF);

        // contention from reset: CPU first, then alternate
        reset = 1'b0;
        #1;
        chk("s2_rst_rdata", cpu_rdata, 0);
        tick();
        reset = 1'b1;
        drv_cpu(1'b1, 1'b1, 32'h30, 32'hC0C0C0C0);
        drv_ext(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
        #1;
        chk("s2_c1_cpu", cpu_gnt, 1);
        chk("s2_c1_ext", ext_gnt, 0);
        chk("s2_c1_wr", d_wr_en, 1);
        chk("s2_c1_wdata", dWdata, 32'hC0C0C0C0);
        tick();
        #1;
        chk("s2_c2_ext", ext_gnt, 1);
        chk("s2_c2_cpu", cpu_gnt, 0);
        chk("s2_c2_wr", d_wr_en, 0);
        chk("s2_c2_daddr", dAddr, 32'h10);
        chk("s2_c2_cpu_rvalid", cpu_rvalid, 0);
        tick();
        #1;
        chk("s2_c3_cpu", cpu_gnt, 1);
        chk("s2_c3_wr", d_wr_en, 1);
        chk("s2_c3_ext_rvalid", ext_rvalid, 1);
        chk("s2_c3_ext_rdata", ext_rdata, 32'hDEADBEEF);
        tick();
        #1;
        chk("s2_c4_ext", ext_gnt, 1);
        chk("s2_c4_ext_rvalid", ext_rvalid, 0);
        tick();
        drv_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        drv_ext(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("s2_tail_ext_rvalid", ext_rvalid, 1);
        chk("s2_tail_cpu_rvalid", cpu_rvalid, 0);
        chk("s2_mem30", mem[12], 32'hC0C0C0C0);
        tick();

        // burst lock: CPU, 8x EXT, CPU, EXT
        drv_cpu(1'b1, 1'b1, 32'h34, 32'h1);
        drv_ext(1'b1, 1'b1, 1'b0, 32'h38, 32'h2);
        for (int i = 0; i < 11; i++) begin
            if (i == 1) ext_lock = 1'b1;
            #1;
            chk($sformatf("s3_ext_%0d", i), ext_gnt,
                ((i >= 1 && i <= 8) || i == 10) ? 1 : 0);
            chk($sformatf("s3_cpu_%0d", i), cpu_gnt,
                (i == 0 || i == 9) ? 1 : 0);
            tick();
        end
        drv_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        drv_ext(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();

        // EXT store then CPU load of the same word
        drv_ext(1'b1, 1'b1, 1'b0, 32'h20, 32'h12345678);
        ext_store_type = 3'b010;
        #1;
        chk("s4_ext_gnt", ext_gnt, 1);
        chk("s4_wr_en", d_wr_en, 1);
        chk("s4_daddr", dAddr, 32'h20);
        chk("s4_wdata", dWdata, 32'h12345678);
        chk("s4_stype", store_type, 3'b010);
        tick();
        drv_ext(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        ext_store_type = 3'b0;
        drv_cpu(1'b1, 1'b0, 32'h20, 32'h0);
        cpu_load_type = 3'b100;
        #1;
        chk("s4_cpu_gnt", cpu_gnt, 1);
        chk("s4_ld_wr_en", d_wr_en, 0);
        chk("s4_ltype", load_type, 3'b100);
        chk("s4_ext_rvalid_a", ext_rvalid, 0);
        tick();
        drv_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        cpu_load_type = 3'b0;
        #1;
        chk("s4_cpu_rvalid", cpu_rvalid, 1);
        chk("s4_cpu_rdata", cpu_rdata, 32'h12345678);
        chk("s4_ext_rvalid_b", ext_rvalid, 0);
        tick();

        // idle cycle clears the lock count but keeps last owner
        drv_ext(1'b1, 1'b0, 1'b1, 32'h4, 32'h0);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("s5_pre_ext_%0d", i), ext_gnt, 1);
            tick();
        end
        drv_ext(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        #1;
        chk("s5_idle_gnt", cpu_gnt | ext_gnt, 0);
        chk("s5_idle_wr", d_wr_en, 0);
        chk("s5_idle_daddr", dAddr, 0);
        chk("s5_idle_wdata", dWdata, 0);
        chk("s5_idle_stype", store_type, 0);
        tick();
        drv_cpu(1'b1, 1'b0, 32'h8, 32'h0);
        drv_ext(1'b1, 1'b0, 1'b1, 32'h4, 32'h0);
        for (int i = 0; i < 9; i++) begin
            #1;
            chk($sformatf("s5_ext_%0d", i), ext_gnt, (i < 8) ? 1 : 0);
            chk($sformatf("s5_cpu_%0d", i), cpu_gnt, (i == 8) ? 1 : 0);
            tick();
        end
        drv_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        drv_ext(1'b1, 1'b0, 1'b0, 32'h4, 32'h0);
        #1;
        chk("s5_rr_ext", ext_gnt, 1);
        tick();
        drv_ext(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        drv_cpu(1'b1, 1'b0, 32'h8, 32'h0);
        drv_ext(1'b1, 1'b0, 1'b0, 32'h4, 32'h0);
        #1;
        chk("s5_rr_cpu", cpu_gnt, 1);
        chk("s5_rr_ext_lose", ext_gnt, 0);
        tick();
        drv_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        drv_ext(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();

        // reset asserted during a granted CPU store
        drv_cpu(1'b1, 1'b1, 32'h24, 32'hBAD0BAD0);
        #1;
        chk("s6_wr_before", d_wr_en, 1);
        #1;
        reset = 1'b0;
        #1;
        chk("s6_wr_after", d_wr_en, 0);
        chk("s6_gnt_after", cpu_gnt, 0);
        chk("s6_daddr_after", dAddr, 0);
        tick();
        chk("s6_mem24", mem[9], 32'h0);
        chk("s6_cpu_rvalid", cpu_rvalid, 0);
        chk("s6_cpu_rdata", cpu_rdata, 0);
        chk("s6_ext_rdata", ext_rdata, 0);
        drv_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter LOCK_MAX, default 8, meaning the maximum consecutive external grants while ext_lock is held.
REQ-002 The block SHALL have port clk  input  1  system clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have ports cpu_req / cpu_we  input  1 each  CPU access request / write (1) or load (0).
REQ-005 The block SHALL have ports cpu_addr, cpu_wdata  input  32 each  CPU address / store data.
REQ-006 The block SHALL have ports cpu_store_type, cpu_load_type  input  3 each  CPU funct3 size codes.
REQ-007 The block SHALL have ports cpu_gnt, cpu_rvalid  output  1 each  CPU access accepted / CPU read data valid.
REQ-008 The block SHALL have port cpu_rdata  output  32  CPU load result.
REQ-009 The block SHALL have ports ext_req, ext_we, ext_lock  input  1 each  external master request / write / burst lock.
REQ-010 The block SHALL have ports ext_addr, ext_wdata  input  32 each, and ext_store_type, ext_load_type  input  3 each, with the same meanings as the CPU ports.
REQ-011 The block SHALL have ports ext_gnt, ext_rvalid  output  1 each, and ext_rdata  output  32, with the same meanings as the CPU ports.
REQ-012 The block SHALL have memory-side ports d_wr_en  output  1; dAddr, dWdata  output  32; store_type, load_type  output  3; dRdata  input  32.

Function
REQ-013 The block SHALL have exactly one owner per cycle, from the states IDLE, OWN_CPU and OWN_EXT.
REQ-014 In the current cycle the block SHALL choose the owner combinationally from the requests and last_owner, as follows:
- only one requester asserts req: that requester owns the cycle;
- both assert req: the requester that did not own the previous granted cycle owns it (round-robin).
REQ-015 Lock override: if the previous grant went to EXT, ext_lock=1, ext_req=1 and lock_cnt<LOCK_MAX, EXT SHALL own the cycle regardless of cpu_req.
REQ-016 gnt SHALL be asserted to the owner only, in the same cycle its request is presented; a requester SHALL hold req and its payload stable until gnt is seen.
REQ-017 The owner's addr, wdata, store_type and load_type SHALL drive the memory-side ports, and d_wr_en SHALL equal owner_we & gnt.
REQ-018 With no owner, d_wr_en SHALL be 0 and the remaining memory outputs SHALL be 0.
REQ-019 A granted load SHALL assert that requester's rvalid for exactly one cycle, the cycle after the grant.
REQ-020 rdata SHALL hold the dRdata value registered at the grant edge, and SHALL keep that value until the next load for the same requester.
REQ-021 A granted store SHALL NOT assert rvalid.
REQ-022 lock_cnt SHALL increment on each EXT grant made while ext_lock=1, saturating at LOCK_MAX.
REQ-023 lock_cnt SHALL clear to 0 on any CPU grant, on any idle cycle, or when ext_lock=0.
REQ-024 When lock_cnt reaches LOCK_MAX and cpu_req=1, the CPU SHALL receive the next cycle, after which round-robin resumes.
REQ-025 last_owner SHALL update only on a granted cycle; idle cycles SHALL leave it unchanged.
REQ-026 Latency SHALL be: grant 0 cycles from req when the requester wins; load data 1 cycle after grant; no bubble between back-to-back grants.
REQ-027 Simultaneous CPU and EXT writes to the same address SHALL be serialised by arbitration, with the later grant taking effect last.

Reset
REQ-028 While reset=0 the block SHALL drive all gnt, rvalid and d_wr_en outputs 0, all rdata 0, state IDLE, lock_cnt 0 and last_owner=EXT (so the CPU wins the first contention).
REQ-029 Reset assertion mid-access SHALL abort that access immediately and asynchronously, with no memory write occurring on the following edge.
REQ-030 After reset release, requests SHALL be serviced from the first rising edge.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
- CPU-only load, cpu_addr=0x10, dRdata=0xDEADBEEF -> cpu_gnt same cycle; next cycle cpu_rvalid=1, cpu_rdata=0xDEADBEEF; ext_gnt=0.
- Both requesting from reset -> CPU, EXT, CPU, EXT grants on consecutive cycles; d_wr_en follows the respective we.
- ext_lock=1, both requesting continuously, LOCK_MAX=8 -> after the first CPU grant, EXT receives 8 consecutive grants, then CPU gets 1 cycle, then EXT again.
- EXT store 0x12345678 to 0x20, then CPU load 0x20 -> d_wr_en=1 only in the EXT cycle; the CPU load returns 0x12345678; ext_rvalid never asserts.
- Idle cycle between grants -> last_owner unchanged, lock_cnt cleared; memory outputs 0.
- reset=0 asserted during a granted CPU store -> d_wr_en drops immediately; memory is unchanged; all outputs return to 0.
